// File: rtl/gray_stream_conv.sv
// Serial R,G,B to weighted grayscale converter with per-frame pixel counting.
// Optional GRAY_STREAM_ROUND_EN: round-half-up before the shift instead of truncating.
module gray_stream_conv #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 64,
  parameter int COEF_W = 9,
  parameter int CR     = 77,
  parameter int CG     = 150,
  parameter int CB     = 29,
  parameter int SHIFT  = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [DATA_W-1:0]                    in_data,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  output logic [DATA_W-1:0]                    out_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 busy,
  output logic                                 done,
  output logic [$clog2(IMG_W*IMG_H+1)-1:0]     pix_cnt
);
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int CNT_W = $clog2(NPIX + 1);
  localparam int ACC_W = DATA_W + COEF_W + 2;
  localparam int SUM_W = ACC_W + 1;

  typedef enum logic [1:0] {IDLE, FILL, CALC, OUTPUT} state_t;

  state_t            state, state_nxt;
  logic [1:0]        ch_idx;
  logic [DATA_W-1:0] r_q, g_q, b_q;
  logic              in_xfer, out_xfer, last_pix;
  logic [ACC_W-1:0]  acc;
  logic [SUM_W-1:0]  sum, shifted;
  logic [DATA_W-1:0] pix_res;

  assign in_ready  = (state == FILL);
  assign out_valid = (state == OUTPUT);
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;
  assign last_pix  = (pix_cnt == CNT_W'(NPIX - 1));

  // Full-width weighted sum; the extra sum bit absorbs the rounding add.
  always_comb begin
    acc = ACC_W'(CR) * ACC_W'(r_q) + ACC_W'(CG) * ACC_W'(g_q) + ACC_W'(CB) * ACC_W'(b_q);
`ifdef GRAY_STREAM_ROUND_EN
    sum = {1'b0, acc} + (SUM_W'(1) << (SHIFT - 1));
`else
    sum = {1'b0, acc};
`endif
    shifted = sum >> SHIFT;
    pix_res = (|shifted[SUM_W-1:DATA_W]) ? {DATA_W{1'b1}} : shifted[DATA_W-1:0];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FILL;
      FILL:    if (in_xfer && ch_idx == 2'd2) state_nxt = CALC;
      CALC:    state_nxt = OUTPUT;
      OUTPUT:  if (out_xfer) state_nxt = last_pix ? IDLE : FILL;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ch_idx   <= '0;
      r_q      <= '0;
      g_q      <= '0;
      b_q      <= '0;
      out_data <= '0;
      pix_cnt  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        IDLE: if (start) begin
          busy    <= 1'b1;
          pix_cnt <= '0;
          ch_idx  <= '0;
        end
        FILL: if (in_xfer) begin
          case (ch_idx)
            2'd0:    r_q <= in_data;
            2'd1:    g_q <= in_data;
            default: b_q <= in_data;
          endcase
          ch_idx <= (ch_idx == 2'd2) ? 2'd0 : ch_idx + 2'd1;
        end
        CALC: out_data <= pix_res;
        OUTPUT: if (out_xfer) begin
          pix_cnt <= pix_cnt + CNT_W'(1);
          if (last_pix) begin
            done <= 1'b1;
            busy <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_gray_stream_conv.sv
// Scoreboard bench: two 2x2-frame instances (default weights and saturating 200/200/200)
// share all inputs; expected pixels are queued on stimulus and popped on output transfers.
module tb_gray_stream_conv;
  logic       clk = 1'b0;
  logic       rst, start, in_valid, out_ready;
  logic [7:0] in_data;

  logic       in_ready, out_valid, busy, done;
  logic [7:0] out_data;
  logic [2:0] pix_cnt;
  logic       in_ready2, out_valid2, busy2, done2;
  logic [7:0] out_data2;
  logic [2:0] pix_cnt2;

  int n_tests = 0;
  int n_fail  = 0;
  int done_seen = 0;
  logic [7:0] q1[$], q2[$];

  gray_stream_conv #(.IMG_W(2), .IMG_H(2)) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .pix_cnt(pix_cnt));

  gray_stream_conv #(.IMG_W(2), .IMG_H(2), .CR(200), .CG(200), .CB(200)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready2), .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready),
    .busy(busy2), .done(done2), .pix_cnt(pix_cnt2));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gray(input int r, g, b, cr, cg, cb);
    int acc;
    acc = cr * r + cg * g + cb * b;
`ifdef GRAY_STREAM_ROUND_EN
    acc = acc + 128;
`endif
    acc = acc >> 8;
    return (acc > 255) ? 8'd255 : acc[7:0];
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (q1.size() == 0) chk("unexpected_pix", 1, 0);
        else chk("pix", out_data, q1.pop_front());
      end
      if (out_valid2 && out_ready) begin
        if (q2.size() == 0) chk("unexpected_pix_sat", 1, 0);
        else chk("pix_sat", out_data2, q2.pop_front());
      end
      if (done) done_seen++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_ch(input logic [7:0] d, input bit gaps);
    int t;
    if (gaps) repeat ($urandom_range(0, 2)) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      tick();
    end
    in_data  = d;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 50) begin
      tick();
      t++;
    end
    if (t >= 50) chk("in_ready_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic send_pixel(input logic [7:0] r, g, b, input bit gaps, input bit lat);
    send_ch(r, gaps);
    send_ch(g, gaps);
    send_ch(b, gaps);
    q1.push_back(gray(r, g, b, 77, 150, 29));
    q2.push_back(gray(r, g, b, 200, 200, 200));
    if (lat) begin
      @(negedge clk); chk("lat_calc_no_valid", out_valid, 0);
      @(negedge clk); chk("lat_out_valid", out_valid, 1);
    end
  endtask

  task automatic wait_xfer;
    int t;
    t = 0;
    @(negedge clk);
    while (!(out_valid && out_ready) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("out_xfer_timeout", 0, 1);
  endtask

  task automatic pulse_start;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    logic [7:0] hold;
    int t;
    rst = 1'b1; start = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_pix_cnt", pix_cnt, 0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst_beats_start", busy, 0);

    // Frame 1
    pulse_start();
    @(negedge clk);
    chk("start_busy", busy, 1);
    chk("start_pix_cnt", pix_cnt, 0);
    send_pixel(8'd255, 8'd255, 8'd255, 1'b0, 1'b1);
    send_pixel(8'd100, 8'd100, 8'd100, 1'b1, 1'b0);
    send_pixel(8'd255, 8'd0, 8'd0, 1'b1, 1'b0);
    wait_xfer();
    pulse_start();
    @(negedge clk);
    chk("mid_start_cnt", pix_cnt, 3);
    chk("mid_start_busy", busy, 1);
    send_pixel(8'd0, 8'd255, 8'd0, 1'b0, 1'b0);
    wait_xfer();
    chk("done_not_early", done, 0);
    chk("pre_last_cnt", pix_cnt, 3);
    @(negedge clk);
    chk("done_pulse", done, 1);
    chk("done_busy_low", busy, 0);
    chk("frame_cnt", pix_cnt, 4);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    in_valid = 1'b1; in_data = 8'd55;
    repeat (3) @(negedge clk);
    chk("idle_in_ready", in_ready, 0);
    chk("idle_out_valid", out_valid, 0);
    chk("idle_cnt_hold", pix_cnt, 4);
    in_valid = 1'b0;

    // Frame 2 with backpressure and random gaps
    pulse_start();
    @(negedge clk);
    chk("restart_cnt_clr", pix_cnt, 0);
    chk("restart_busy", busy, 1);
    send_pixel(8'd0, 8'd0, 8'd255, 1'b1, 1'b0);
    wait_xfer();
    tick();
    out_ready = 1'b0;
    send_pixel(8'd10, 8'd20, 8'd30, 1'b1, 1'b0);
    t = 0;
    @(negedge clk);
    while (!out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) chk("bp_valid_timeout", 0, 1);
    hold = out_data;
    repeat (10) begin
      @(negedge clk);
      chk("bp_data_stable", out_data, hold);
      chk("bp_valid_held", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_cnt_hold", pix_cnt, 1);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_cnt", pix_cnt, 2);
    chk("bp_release_single", out_valid, 0);
    send_pixel(8'($urandom), 8'($urandom), 8'($urandom), 1'b1, 1'b0);
    send_pixel(8'($urandom), 8'($urandom), 8'($urandom), 1'b1, 1'b0);
    wait_xfer();
    @(negedge clk);
    chk("done2_pulse", done, 1);
    chk("frame2_cnt", pix_cnt, 4);

    // Reset with a partial pixel, then a fresh frame
    pulse_start();
    send_ch(8'd11, 1'b0);
    send_ch(8'd22, 1'b0);
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_cnt", pix_cnt, 0);
    rst = 1'b0;
    pulse_start();
    send_pixel(8'd40, 8'd80, 8'd120, 1'b1, 1'b0);
    wait_xfer();
    @(negedge clk);
    chk("after_rst_cnt", pix_cnt, 1);
    chk("after_rst_no_done", done, 0);

    repeat (3) @(negedge clk);
    chk("q_drained", q1.size(), 0);
    chk("q_sat_drained", q2.size(), 0);
    chk("done_count", done_seen, 2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
